sequenciador_animacao: RTL

SEQUENCIADOR_ANIMACAO -- requirements
Module: sequenciador_animacao

---
 rtl/sequenciador_animacao.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/sequenciador_animacao.sv
`default_nettype none
// ============================================================================
//  Module      : sequenciador_animacao
//  Description : Sprite frame sequencer for the pet display. Produces the
//                current frame index for the sprite ROM from the pet state,
//                advancing once every DIV_QUADRO clocks. Looping states wrap,
//                one-shot states stop on their last frame and pulse
//                fim_animacao, MORTO holds frame 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequenciador_animacao #(
    parameter int DIV_QUADRO = 12500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] estado,
    output logic [1:0] quadro,
    output logic       fim_animacao,
    output logic       ocupado
);

    // Pet state codes
    localparam logic [2:0] c_idle          = 3'b000;
    localparam logic [2:0] c_dormindo      = 3'b001;
    localparam logic [2:0] c_acordando     = 3'b010;
    localparam logic [2:0] c_comendo       = 3'b011;
    localparam logic [2:0] c_limpando_boca = 3'b100;
    localparam logic [2:0] c_dando_aula    = 3'b101;
    localparam logic [2:0] c_voltando      = 3'b110;
    localparam logic [2:0] c_morto         = 3'b111;

    // Sequencer FSM encoding
    localparam logic       c_rodando   = 1'b0;
    localparam logic       c_concluido = 1'b1;

    // Last prescaler count before the frame tick
    localparam logic [23:0] c_tick_max = 24'(DIV_QUADRO - 1);

    logic [2:0]  r_estado_reg;
    logic [23:0] r_prescaler;
    logic [1:0]  r_quadro;
    logic        r_fim;
    logic        r_state;

    logic        w_state_nxt;
    logic        w_mudanca;
    logic        w_tick;
    logic [1:0]  w_last;
    logic        w_oneshot;
    logic        w_fim_set;
    logic [1:0]  w_quadro_nxt;
    logic        w_ocupado;

    assign w_mudanca = (estado != r_estado_reg);
    assign w_tick    = (r_prescaler == c_tick_max);

    // Frame table: last frame index and one-shot flag for the latched state
    always_comb begin
        w_last    = 2'd3;
        w_oneshot = 1'b0;
        case (r_estado_reg)
            c_idle:          begin w_last = 2'd3; w_oneshot = 1'b0; end
            c_dormindo:      begin w_last = 2'd1; w_oneshot = 1'b0; end
            c_acordando:     begin w_last = 2'd3; w_oneshot = 1'b1; end
            c_comendo:       begin w_last = 2'd3; w_oneshot = 1'b0; end
            c_limpando_boca: begin w_last = 2'd2; w_oneshot = 1'b1; end
            c_dando_aula:    begin w_last = 2'd3; w_oneshot = 1'b0; end
            c_voltando:      begin w_last = 2'd2; w_oneshot = 1'b1; end
            c_morto:         begin w_last = 2'd0; w_oneshot = 1'b0; end
            default:         begin w_last = 2'd3; w_oneshot = 1'b0; end
        endcase
    end

    // Frame advance: step, wrap for loops, hold at last frame otherwise
    always_comb begin
        w_quadro_nxt = r_quadro;
        w_fim_set    = 1'b0;
        if (r_state == c_rodando && w_tick) begin
            if (r_quadro < w_last) begin
                w_quadro_nxt = r_quadro + 2'd1;
            end else if (w_oneshot) begin
                w_fim_set = 1'b1;
            end else begin
                w_quadro_nxt = 2'd0;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_rodando;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: a state change always restarts; one-shot end parks it
    always_comb begin
        w_state_nxt = r_state;
        if (w_mudanca) begin
            w_state_nxt = c_rodando;
        end else if (w_fim_set) begin
            w_state_nxt = c_concluido;
        end
    end

    // FSM output: busy while a one-shot animation is still running
    always_comb begin
        w_ocupado = 1'b0;
        if (r_state == c_rodando && w_oneshot) begin
            w_ocupado = 1'b1;
        end
    end

    // Datapath: state latch, prescaler, frame index and end-of-animation pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado_reg <= c_idle;
            r_prescaler  <= 24'd0;
            r_quadro     <= 2'd0;
            r_fim        <= 1'b0;
        end else if (w_mudanca) begin
            r_estado_reg <= estado;
            r_prescaler  <= 24'd0;
            r_quadro     <= 2'd0;
            r_fim        <= 1'b0;
        end else begin
            r_prescaler  <= w_tick ? 24'd0 : r_prescaler + 24'd1;
            r_quadro     <= w_quadro_nxt;
            r_fim        <= w_fim_set;
        end
    end

    assign quadro       = r_quadro;
    assign fim_animacao = r_fim;
    assign ocupado      = w_ocupado;

endmodule
`default_nettype wire
